// File: rtl/mem_io_pkg.sv
// Shared types and address map for the memory/IO controller.
// The region decode is kept here so every user of the map classifies addresses the same way.
package mem_io_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mio_state_t;

    typedef enum logic [1:0] {REG_RAM, REG_LED, REG_SW, REG_BAD} mio_region_t;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;
    localparam logic [8:0] RAM_TOP  = 9'h0FF;

    function automatic mio_region_t mio_decode(input logic [8:0] addr,
                                               input logic [8:0] led_addr = LED_ADDR,
                                               input logic [8:0] sw_addr  = SW_ADDR);
        mio_region_t region;
        if (addr <= RAM_TOP) begin
            region = REG_RAM;
        end else if (addr == led_addr) begin
            region = REG_LED;
        end else if (addr == sw_addr) begin
            region = REG_SW;
        end else begin
            region = REG_BAD;
        end
        return region;
    endfunction

endpackage

// File: rtl/mem_io_ctrl_decode.sv
// Registered region decode, loaded alongside the holding registers so the
// region is ready in the very first ACCESS cycle.
module mio_decode_unit
    import mem_io_pkg::*;
#(
    parameter logic [8:0] LED_A = LED_ADDR,
    parameter logic [8:0] SW_A  = SW_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [8:0]  addr_i,
    output mio_region_t region_o
);

    mio_region_t region_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            region_q <= REG_RAM;
        end else if (load_i) begin
            region_q <= mio_decode(addr_i, LED_A, SW_A);
        end
    end

    assign region_o = region_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller: one load or store at a time, routed to the external
// synchronous-read RAM, the LED register or the switch port in a fixed 3-cycle sequence.
module mem_io_ctrl #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                RAM_AW   = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [7:0]        sw_in,
    output logic [7:0]        ledr_out,
    output logic              addr_err
);

    import mem_io_pkg::*;

    mio_state_t        state_q, state_d;
    mio_region_t       region;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] io_q, io_d;
    logic [7:0]        ledr_q, ledr_d;
    logic              err_q, err_d;
    logic              accept;

    assign accept = req_valid && (state_q == IDLE);

    mio_decode_unit #(
        .LED_A (LED_ADDR),
        .SW_A  (SW_ADDR)
    ) u_decode (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .load_i   (accept),
        .addr_i   (req_addr),
        .region_o (region)
    );

    always_comb begin
        state_d = state_q;
        io_d    = io_q;
        ledr_d  = ledr_q;
        err_d   = err_q;
        case (state_q)
            IDLE:   if (accept) state_d = ACCESS;
            ACCESS: begin
                state_d = RESP;
                io_d    = '0;
                // IO side effects and the switch sample all land on the ACCESS->RESP edge.
                case (region)
                    REG_LED: if (write_q) ledr_d = wdata_q[7:0];
                             else         io_d   = {{(DATA_W-8){1'b0}}, ledr_q};
                    REG_SW:  if (!write_q) io_d  = {{(DATA_W-8){1'b0}}, sw_in};
                    REG_BAD: err_d = 1'b1;
                    default: ;
                endcase
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            io_q    <= '0;
            ledr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            io_q    <= io_d;
            ledr_q  <= ledr_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Write strobe is combinational from state so a reset during ACCESS kills it at once.
    assign ram_we    = (state_q == ACCESS) && write_q && (region == REG_RAM);
    assign ram_din   = ram_we ? wdata_q : '0;
    assign ram_addr  = addr_q[RAM_AW-1:0];
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (state_q != RESP)                 ? '0       :
                       (region == REG_RAM && !write_q)  ? ram_dout : io_q;
    assign ledr_out  = ledr_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed scenarios plus randomized
// traffic compared against an address-map reference model.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din, ram_dout;
    logic [7:0]  sw_in, ledr_out;
    logic        addr_err;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [7:0]  ref_led;
    logic        ref_err;
    int          n_total = 0;
    int          n_bad   = 0;
    int          we_cnt  = 0;

    always #5 clk = ~clk;

    mem_io_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .sw_in     (sw_in),
        .ledr_out  (ledr_out),
        .addr_err  (addr_err)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            we_cnt <= we_cnt + 1;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction, checked in each of its three cycles against the address map.
    task automatic do_req(input logic w, input logic [8:0] a, input logic [15:0] d, input logic [7:0] sw);
        logic [15:0] exp_rd;
        logic        is_ram, is_led, is_sw;
        logic [7:0]  led_before;
        int          we_before;
        is_ram = (a < 9'h100);
        is_led = (a == 9'h100);
        is_sw  = (a == 9'h140);
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; sw_in = sw;
        exp_rd = 16'h0000;
        if (!w) begin
            if (is_ram)      exp_rd = ref_mem[a[7:0]];
            else if (is_led) exp_rd = {8'h00, ref_led};
            else if (is_sw)  exp_rd = {8'h00, sw};
        end
        led_before = ref_led;
        we_before  = we_cnt;
        if (w && is_ram) ref_mem[a[7:0]] = d;
        if (w && is_led) ref_led = d[7:0];
        if (!is_ram && !is_led && !is_sw) ref_err = 1;
        @(negedge clk);
        req_valid = 0; req_write = 1'($urandom); req_addr = 9'($urandom); req_wdata = 16'($urandom);
        chk("ready_access", req_ready, 0);
        chk("rsp_access", rsp_valid, 0);
        chk("we_access", ram_we, w && is_ram);
        chk("led_access", ledr_out, led_before);
        if (w && is_ram) begin
            chk("ram_addr", ram_addr, a[7:0]);
            chk("ram_din", ram_din, d);
        end
        @(negedge clk);
        sw_in = ~sw;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("we_resp", ram_we, 0);
        chk("ready_resp", req_ready, 0);
        chk("ledr", ledr_out, ref_led);
        chk("addr_err", addr_err, ref_err);
        chk("we_pulses", we_cnt - we_before, (w && is_ram) ? 1 : 0);
        @(negedge clk);
        chk("rsp_idle", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        logic [8:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        ref_led = 8'h00; ref_err = 0;
        reset_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; sw_in = '0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_led", ledr_out, 0);
        chk("rst_err", addr_err, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;

        do_req(1, 9'h06C, 16'h002A, 8'h00);
        do_req(0, 9'h06C, 16'h0000, 8'h00);
        do_req(1, 9'h100, 16'h01A5, 8'h00);
        do_req(0, 9'h100, 16'h0000, 8'h00);
        do_req(0, 9'h140, 16'h0000, 8'h3C);
        do_req(1, 9'h140, 16'hFFFF, 8'h3C);
        chk("err_clean", addr_err, 0);

        do_req(1, 9'h000, 16'h1111, 8'h00);
        do_req(1, 9'h001, 16'h2222, 8'h00);
        do_req(1, 9'h002, 16'h3333, 8'h00);
        // Three loads with req_valid held high: accepts every third cycle.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("held_ready", req_ready, (k % 3) == 0);
            chk("held_rsp", rsp_valid, (k % 3) == 2);
            if ((k % 3) == 2) chk("held_rdata", rsp_rdata, ref_mem[k / 3]);
            if ((k % 3) == 0) begin
                req_valid = 1; req_write = 0; req_addr = 9'(k / 3);
            end
            if (k == 8) req_valid = 0;
        end

        do_req(1, 9'h120, 16'h00FF, 8'h00);
        do_req(0, 9'h1FF, 16'h0000, 8'h00);
        chk("err_set", addr_err, 1);

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 3))
                0: a = 9'($urandom_range(0, 254));
                1: a = 9'h100;
                2: a = 9'h140;
                default: begin
                    a = 9'h100 | 9'($urandom_range(1, 255));
                    if (a == 9'h140) a = 9'h141;
                end
            endcase
            d = 16'($urandom);
            do_req(1'($urandom), a, d, 8'($urandom));
        end
        chk("err_sticky", addr_err, 1);

        // Reset during the ACCESS cycle of a RAM store.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 9'h0FF; req_wdata = 16'hBEEF;
        @(negedge clk);
        req_valid = 0;
        chk("mid_we_before", ram_we, 1);
        reset_n = 0;
        #1;
        chk("mid_we_drop", ram_we, 0);
        chk("mid_led", ledr_out, 0);
        chk("mid_err", addr_err, 0);
        chk("mid_ready", req_ready, 1);
        chk("mid_rsp", rsp_valid, 0);
        ref_led = 8'h00; ref_err = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_hold_rsp", rsp_valid, 0);
        end
        reset_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_ready", req_ready, 1);
        end
        do_req(0, 9'h100, 16'h0000, 8'h00);
        do_req(0, 9'h06C, 16'h0000, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
